step_ctrl: RTL and testbench

STEP_CTRL -- requirements
Module: step_ctrl

---
 rtl/step_ctrl.sv | 177 +++++++++++++++++
 tb/tb_step_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/step_ctrl.sv
// Single-step / run / breakpoint controller for a datapath PC.
// Debounces a raw push-button and gates the datapath advance enable (pc_en).
module step_ctrl #(
  parameter int PC_W            = 16,
  parameter int CNT_W           = 16,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int STEP_BURST      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn,
  input  logic [1:0]       mode,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  output logic             pc_en,
  output logic             halted,
  output logic             btn_pulse,
  output logic             bp_hit,
  output logic [CNT_W-1:0] step_count
);

  localparam logic [1:0]  MODE_HALT   = 2'b00;
  localparam logic [1:0]  MODE_STEP   = 2'b01;
  localparam logic [1:0]  MODE_RUN_BP = 2'b11;
  localparam logic [15:0] DB_LAST     = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]  BURST_LAST  = 8'(STEP_BURST - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BURST = 2'b01,
    ST_RUN   = 2'b10,
    ST_BREAK = 2'b11
  } state_t;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             db_q, db_d;
  logic [15:0]      db_cnt_q, db_cnt_d;
  logic             btn_pulse_q, btn_pulse_d;
  state_t           state_q, state_d;
  logic [7:0]       burst_cnt_q, burst_cnt_d;
  logic             skip_q, skip_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] step_count_q, step_count_d;
  logic             bp_match;
  logic             pc_en_s;

  // State register: every flop of the block, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      db_q         <= 1'b0;
      db_cnt_q     <= 16'd0;
      btn_pulse_q  <= 1'b0;
      state_q      <= ST_IDLE;
      burst_cnt_q  <= 8'd0;
      skip_q       <= 1'b0;
      mode_q       <= MODE_HALT;
      step_count_q <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      db_q         <= db_d;
      db_cnt_q     <= db_cnt_d;
      btn_pulse_q  <= btn_pulse_d;
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      skip_q       <= skip_d;
      mode_q       <= mode_d;
      step_count_q <= step_count_d;
    end
  end

  // Synchroniser and debouncer; the press pulse fires as the level rises.
  always_comb begin
    sync1_d     = btn;
    sync2_d     = sync1_q;
    db_d        = db_q;
    db_cnt_d    = 16'd0;
    btn_pulse_d = 1'b0;
    if (sync2_q != db_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_d        = sync2_q;
        btn_pulse_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 16'd1;
      end
    end else begin
      db_cnt_d = 16'd0;
    end
  end

  // skip_q lets the single resume cycle out of BREAK step past the matching PC.
  assign bp_match = bp_en && (pc == bp_addr) && (mode == MODE_RUN_BP) && !skip_q;

  // Next-state logic: HALT and mode changes take priority over button pulses.
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    skip_d      = 1'b0;
    mode_d      = mode;
    if (mode == MODE_HALT) begin
      state_d     = ST_IDLE;
      burst_cnt_d = 8'd0;
    end else if (mode != mode_q) begin
      state_d     = mode[1] ? ST_RUN : ST_IDLE;
      burst_cnt_d = 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          burst_cnt_d = 8'd0;
          if ((mode == MODE_STEP) && btn_pulse_q) begin
            state_d = ST_BURST;
          end else if (mode[1]) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_BURST: begin
          if (burst_cnt_q == BURST_LAST) begin
            state_d     = ST_IDLE;
            burst_cnt_d = 8'd0;
          end else begin
            state_d     = ST_BURST;
            burst_cnt_d = burst_cnt_q + 8'd1;
          end
        end
        ST_RUN: begin
          if (!mode[1]) begin
            state_d = ST_IDLE;
          end else if (bp_match) begin
            state_d = ST_BREAK;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_BREAK: begin
          if (btn_pulse_q) begin
            state_d = ST_RUN;
            skip_d  = 1'b1;
          end else begin
            state_d = ST_BREAK;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          burst_cnt_d = 8'd0;
        end
      endcase
    end
  end

  // Output logic: pc_en drops combinationally on a breakpoint match.
  always_comb begin
    pc_en_s = 1'b0;
    if (mode == MODE_HALT) begin
      pc_en_s = 1'b0;
    end else begin
      case (state_q)
        ST_BURST: pc_en_s = 1'b1;
        ST_RUN:   pc_en_s = !bp_match;
        default:  pc_en_s = 1'b0;
      endcase
    end
    step_count_d = step_count_q + {{(CNT_W-1){1'b0}}, pc_en_s};
  end

  assign pc_en      = pc_en_s;
  assign halted     = !pc_en_s;
  assign btn_pulse  = btn_pulse_q;
  assign bp_hit     = (state_q == ST_BREAK);
  assign step_count = step_count_q;

endmodule

// File: tb/tb_step_ctrl.sv
// Randomised scoreboard bench for step_ctrl: a behavioural model predicts each
// cycle's outputs into a queue; a negedge monitor pops and compares.
module tb_step_ctrl;

  localparam int DB    = 4;
  localparam int BURST = 3;

  logic        clk = 1'b0;
  logic        rst, btn, bp_en;
  logic [1:0]  mode;
  logic [15:0] bp_addr, pc;
  logic        pc_en, halted, btn_pulse, bp_hit;
  logic [7:0]  step_count;

  step_ctrl #(.PC_W(16), .CNT_W(8), .DEBOUNCE_CYCLES(DB), .STEP_BURST(BURST)) dut (
    .clk(clk), .rst(rst), .btn(btn), .mode(mode), .bp_en(bp_en),
    .bp_addr(bp_addr), .pc(pc), .pc_en(pc_en), .halted(halted),
    .btn_pulse(btn_pulse), .bp_hit(bp_hit), .step_count(step_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pulse;
    logic       en;
    logic       hlt;
    logic       hit;
    logic [7:0] cnt;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // inputs to apply after the next edge
  logic        nx_rst, nx_btn, nx_bp_en;
  logic [1:0]  nx_mode;
  logic [15:0] nx_bp_addr;
  logic [15:0] pc_v;

  // behavioural model
  bit   m_s1, m_s2, m_db, m_pulse, m_break, m_running, m_skip, m_pc_en;
  int   m_run, m_burst_left, m_count;
  logic [1:0] m_mode_prev;

  function automatic bit model_match();
    return (mode == 2'b11) && bp_en && (pc == bp_addr) && !m_skip;
  endfunction

  function automatic bit model_pc_en();
    if (mode == 2'b00)     return 1'b0;
    if (m_burst_left > 0)  return 1'b1;
    if (m_running)         return !model_match();
    return 1'b0;
  endfunction

  task automatic model_edge();
    bit new_pulse;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_db = 0; m_run = 0; m_pulse = 0;
      m_burst_left = 0; m_break = 0; m_running = 0; m_skip = 0;
      m_count = 0; m_mode_prev = 2'b00;
      return;
    end
    new_pulse = 0;
    if (m_s2 != m_db) begin
      m_run++;
      if (m_run == DB) begin
        m_db = m_s2; m_run = 0; new_pulse = m_s2;
      end
    end else begin
      m_run = 0;
    end
    m_s2 = m_s1;
    m_s1 = btn;
    m_count = (m_count + int'(m_pc_en)) % 256;
    if (mode == 2'b00) begin
      m_burst_left = 0; m_break = 0; m_running = 0; m_skip = 0;
    end else if (mode != m_mode_prev) begin
      m_burst_left = 0; m_break = 0; m_running = mode[1]; m_skip = 0;
    end else if (m_burst_left > 0) begin
      m_burst_left--;
    end else if (m_break) begin
      if (m_pulse) begin
        m_break = 0; m_running = 1; m_skip = 1;
      end
    end else if (m_running) begin
      if (model_match()) begin
        m_break = 1; m_running = 0;
      end
      m_skip = 0;
    end else begin
      if (mode == 2'b01 && m_pulse) m_burst_left = BURST;
      else if (mode[1])             m_running = 1;
    end
    m_mode_prev = mode;
    m_pulse = new_pulse;
  endtask

  task automatic tick();
    obs_t e;
    @(posedge clk);
    cyc++;
    model_edge();
    if (m_pc_en) pc_v = pc_v + 16'd1;
    #1;
    rst = nx_rst; btn = nx_btn; mode = nx_mode; bp_en = nx_bp_en;
    bp_addr = nx_bp_addr; pc = pc_v;
    m_pc_en = model_pc_en();
    e.pulse = m_pulse;
    e.en    = m_pc_en;
    e.hlt   = !m_pc_en;
    e.hit   = m_break;
    e.cnt   = 8'(m_count);
    exp_q.push_back(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Monitor: compare the DUT against the oldest prediction each cycle.
  always @(negedge clk) begin
    obs_t g, e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {btn_pulse, pc_en, halted, bp_hit, step_count};
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL outputs cycle %0d: got pulse=%b pc_en=%b halted=%b bp_hit=%b cnt=%0d, required pulse=%b pc_en=%b halted=%b bp_hit=%b cnt=%0d",
                 cyc, g.pulse, g.en, g.hlt, g.hit, g.cnt, e.pulse, e.en, e.hlt, e.hit, e.cnt);
      end
    end
  end

  initial begin
    rst = 1'b1; btn = 1'b0; mode = 2'b00; bp_en = 1'b0; bp_addr = 16'd0; pc = 16'd0;
    nx_rst = 1'b1; nx_btn = 1'b0; nx_mode = 2'b01; nx_bp_en = 1'b0; nx_bp_addr = 16'd0;
    pc_v = 16'd0;
    m_pc_en = 1'b0; m_count = 0; m_mode_prev = 2'b00;

    // single press in STEP mode
    run(3);
    nx_rst = 1'b0; run(2);
    nx_btn = 1'b1; run(20);
    nx_btn = 1'b0; run(12);

    // bouncing button: toggles every 2 cycles, never debounced
    for (int i = 0; i < 40; i++) begin
      nx_btn = ((i / 2) % 2) == 1;
      tick();
    end
    nx_btn = 1'b0; run(10);

    // second press while a burst is running
    nx_btn = 1'b1; run(7);
    nx_btn = 1'b0; run(6);
    nx_btn = 1'b1; run(8);
    nx_btn = 1'b0; run(12);

    // breakpoint at 0x0010, then resume with one press
    pc_v = 16'd0;
    nx_mode = 2'b11; nx_bp_en = 1'b1; nx_bp_addr = 16'h0010;
    run(30);
    nx_btn = 1'b1; run(9);
    nx_btn = 1'b0; run(12);

    // free run wraps the 8-bit step counter
    nx_rst = 1'b1; run(1);
    nx_rst = 1'b0; nx_mode = 2'b10; nx_bp_en = 1'b0; run(256 + 8);

    // reset in the middle of a burst
    nx_mode = 2'b01; nx_rst = 1'b1; run(2);
    nx_rst = 1'b0; nx_btn = 1'b1;
    for (int i = 0; i < 20 && m_burst_left == 0; i++) tick();
    nx_btn = 1'b0; run(1);
    nx_rst = 1'b1; run(1);
    nx_rst = 1'b0; run(20);

    // random mix of modes, presses, breakpoints and resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 59) == 0) nx_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0)  nx_btn = ~nx_btn;
      if ($urandom_range(0, 39) == 0) nx_bp_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 29) == 0) nx_bp_addr = pc_v + 16'($urandom_range(0, 12));
      nx_rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    nx_rst = 1'b0; run(3);

    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending predictions, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
